// File: rtl/signed_accum_sequencer.sv
// Running signed acc +/- op over a valid/ready operand stream with a sticky overflow flag.
// Latency: result registered on the last accepted beat; out_valid rises the next cycle. Holds in DONE until out_ready.
// Optional ACCUM_SATURATE_EN: on overflow, clamp acc toward its prior sign instead of wrapping.
module signed_accum_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ok,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic             err;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic [WIDTH-1:0] acc_nxt;

  // Subtraction is acc + ~op + 1, so overflow is judged on the inverted operand.
  assign b_eff = in_sub ? ~in_data : in_data;
  assign sum   = acc + b_eff + {{(WIDTH-1){1'b0}}, in_sub};
  assign ovf   = ~(acc[WIDTH-1] ^ b_eff[WIDTH-1]) & (b_eff[WIDTH-1] ^ sum[WIDTH-1]);

`ifdef ACCUM_SATURATE_EN
  assign acc_nxt = !ovf ? sum :
                   acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign acc_nxt = sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      err       <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      err       <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            acc      <= '0;
            err      <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (in_valid && in_ready) begin
            acc <= acc_nxt;
            err <= err | ovf;
            cnt <= (&cnt) ? cnt : cnt + 1'b1;
            if (in_last) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          // acc/err/cnt stay visible after the handshake until the next start.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_result = acc;
  assign out_ok     = ~err;
  assign out_count  = cnt;

endmodule

// File: tb/tb_signed_accum_sequencer.sv
// Directed bench for signed_accum_sequencer; expected values hand-derived per build variant.
module tb_signed_accum_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, clear, in_valid, in_sub, in_last, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_ok, busy;
  logic [7:0] out_result, out_count;

  int tests = 0;
  int fails = 0;

  signed_accum_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sub(in_sub), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_ok(out_ok),
    .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] r,
                           input logic ok, input logic [7:0] c);
    check({tag, ".valid"},  {31'd0, out_valid}, {31'd0, v});
    check({tag, ".result"}, {24'd0, out_result}, {24'd0, r});
    check({tag, ".ok"},     {31'd0, out_ok}, {31'd0, ok});
    check({tag, ".count"},  {24'd0, out_count}, {24'd0, c});
  endtask

  // All helpers begin and end at a falling edge.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input logic s, input logic l);
    in_valid = 1'b1; in_data = d; in_sub = s; in_last = l;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_sub = 1'b0; in_last = 1'b0; in_data = 8'h00;
  endtask

  task automatic finish_calc(input string tag);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".idle_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".idle_busy"},  {31'd0, busy}, 32'd0);
  endtask

  logic [7:0] exp_r;

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_sub = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    check_out("reset", 1'b0, 8'h00, 1'b1, 8'h00);
    check("reset.in_ready", {31'd0, in_ready}, 32'd0);
    check("reset.busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // operand offered in IDLE must be ignored
    in_valid = 1'b1; in_data = 8'h11; in_last = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check_out("idle_beat", 1'b0, 8'h00, 1'b1, 8'h00);

    // 100 + 27 = 127 exactly
    do_start();
    check("run.in_ready", {31'd0, in_ready}, 32'd1);
    check("run.busy", {31'd0, busy}, 32'd1);
    beat(8'd100, 1'b0, 1'b0);
    check("p127.mid_valid", {31'd0, out_valid}, 32'd0);
    beat(8'd27, 1'b0, 1'b1);
    check_out("p127", 1'b1, 8'h7F, 1'b1, 8'd2);
    check("p127.in_ready", {31'd0, in_ready}, 32'd0);
    finish_calc("p127");

    // 100 + 28 overflows positive
`ifdef ACCUM_SATURATE_EN
    exp_r = 8'h7F;
`else
    exp_r = 8'h80;
`endif
    do_start();
    beat(8'd100, 1'b0, 1'b0);
    beat(8'd28, 1'b0, 1'b1);
    check_out("p128", 1'b1, exp_r, 1'b0, 8'd2);
    finish_calc("p128");

    // 0 - (-128) overflows
    do_start();
    beat(8'h80, 1'b1, 1'b1);
    check_out("sub_min", 1'b1, exp_r, 1'b0, 8'd1);
    finish_calc("sub_min");

    // -50 - 78 = -128 fits
    do_start();
    beat(8'hCE, 1'b0, 1'b0);
    beat(8'd78, 1'b1, 1'b1);
    check_out("m128", 1'b1, 8'h80, 1'b1, 8'd2);
    finish_calc("m128");

    // -50 - 79 overflows negative
`ifdef ACCUM_SATURATE_EN
    exp_r = 8'h80;
`else
    exp_r = 8'h7F;
`endif
    do_start();
    beat(8'hCE, 1'b0, 1'b0);
    beat(8'd79, 1'b1, 1'b1);
    check_out("m129", 1'b1, exp_r, 1'b0, 8'd2);
    finish_calc("m129");

    // sticky error: 127 + 1 + (-1)
`ifdef ACCUM_SATURATE_EN
    exp_r = 8'h7E;
`else
    exp_r = 8'h7F;
`endif
    do_start();
    beat(8'd127, 1'b0, 1'b0);
    beat(8'd1, 1'b0, 1'b0);
    beat(8'hFF, 1'b0, 1'b1);
    check_out("sticky", 1'b1, exp_r, 1'b0, 8'd3);
    finish_calc("sticky");

    // backpressure in DONE with start/in_valid noise
    do_start();
    beat(8'd5, 1'b0, 1'b0);
    out_ready = 1'b1;
    beat(8'd3, 1'b0, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; in_valid = 1'b1; in_data = 8'h22; in_last = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      check_out("bp", 1'b1, 8'd8, 1'b1, 8'd2);
      check("bp.in_ready", {31'd0, in_ready}, 32'd0);
      check("bp.busy", {31'd0, busy}, 32'd1);
    end
    finish_calc("bp");
    check_out("bp.retained", 1'b0, 8'd8, 1'b1, 8'd2);

    // clear during RUN, colliding with an offered beat
    do_start();
    beat(8'd1, 1'b0, 1'b0);
    beat(8'd2, 1'b0, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'd9; in_last = 1'b1;
    @(posedge clk); @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check_out("clear", 1'b0, 8'h00, 1'b1, 8'h00);
    check("clear.busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("clear.later_valid", {31'd0, out_valid}, 32'd0);

    // async reset mid-RUN, off-edge
    do_start();
    beat(8'h90, 1'b0, 1'b0);
    beat(8'h90, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_out("arst", 1'b0, 8'h00, 1'b1, 8'h00);
    check("arst.in_ready", {31'd0, in_ready}, 32'd0);
    check("arst.busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // start with clear in IDLE stays IDLE
    start = 1'b1; clear = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; clear = 1'b0;
    check("sc.busy", {31'd0, busy}, 32'd0);
    check("sc.in_ready", {31'd0, in_ready}, 32'd0);

    // beat counter saturates at 0xFF
    do_start();
    for (int i = 0; i < 259; i++) beat(8'd0, 1'b0, 1'b0);
    beat(8'd0, 1'b0, 1'b1);
    check_out("cnt_sat", 1'b1, 8'h00, 1'b1, 8'hFF);
    finish_calc("cnt_sat");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/signed_accum_sequencer.md
Name: signed_accum_sequencer

Overview:
- Sequences one shared WIDTH-bit two's-complement adder/subtractor over a stream of operands.
- Result is a running signed sum: acc ± op per beat.
- Per-beat overflow uses the sign-bit rule: invalid when the adder operands share a sign and the sum sign differs. This is folded into a sticky validity flag.
- Sits between the operand-entry front end and the result display/consumer. Valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand/accumulator width in bits (two's complement).
- CNT_W, 8, width of beat counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin new accumulation (sampled in IDLE only).
- clear  input  1  synchronous abort to IDLE from any state.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  sequencer accepts operand this cycle.
- in_data  input  WIDTH  signed operand.
- in_sub  input  1  1 = subtract in_data, 0 = add.
- in_last  input  1  final operand of this calculation.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_result  output  WIDTH  accumulated signed result.
- out_ok  output  1  1 = no overflow in any beat, 0 = at least one overflow.
- out_count  output  CNT_W  beats accepted in this calculation.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst_n low, async): state=IDLE; acc=0, err=0, cnt=0. in_ready=0, out_valid=0, busy=0, out_result=0, out_ok=1, out_count=0.
- States: IDLE, RUN, DONE. in_ready=1 only in RUN. out_valid=1 only in DONE. out_result/out_ok/out_count are driven from registers in all states.
- IDLE: on start and not clear → RUN; acc, err, cnt cleared to 0 the same edge.
- RUN, beat accepted (in_valid & in_ready):
  - B' = in_sub ? ~in_data : in_data; cin = in_sub.
  - S = acc + B' + cin, truncated to WIDTH.
  - ovf = ~(acc[MSB] ^ B'[MSB]) & (B'[MSB] ^ S[MSB]).
  - acc <= S; err <= err | ovf; cnt <= cnt+1, saturating at all-ones.
  - in_last on the accepted beat → DONE.
- Latency: result registered the edge the last beat is accepted; out_valid high the following cycle. One beat per cycle max.
- DONE: hold out_valid and all outputs stable until out_ready, then → IDLE. acc/err/cnt are retained for display until the next start.
- out_ok = ~err.
- Boundaries:
  - Subtracting the minimum value (0x80 at WIDTH=8) uses the B' rule, so 0 − (−128) flags overflow.
  - in_valid in IDLE/DONE is not accepted (in_ready=0).
  - start in RUN/DONE is ignored.
  - clear has priority over start and over an accepting beat. clear → IDLE next edge, acc/err/cnt zeroed, out_valid dropped.
  - rst_n asserted mid-RUN or mid-DONE aborts immediately to reset values. A pending output is discarded.
  - out_ready asserted in the same cycle DONE is entered has no effect; the handshake completes on a cycle where out_valid=1.

Optional Feature:
- Macro: ACCUM_SATURATE_EN.
- Defined: on a beat with ovf=1, acc <= acc[MSB] ? most-negative (0x80..0) : most-positive (0x7F..F). err is still set.
- Undefined: acc wraps (plain truncated sum). err is set identically.

Test Plan:
- start; +100, +27(last) → out_valid next cycle after last accept: out_result=0x7F, out_ok=1, out_count=2.
- start; +100, +28(last) → result 0x80, out_ok=0. With ACCUM_SATURATE_EN: result 0x7F, out_ok=0.
- start; sub 0x80(last) from acc=0 → result 0x80, out_ok=0. Separately: −50, sub 78(last) → 0x80, out_ok=1; −50, sub 79 → 0x7F, out_ok=0.
- Overflow then recovery: +127, +1, −1(last) → result 0x7F, out_ok=0 (sticky), count=3.
- Backpressure: hold out_ready=0 for 5 cycles in DONE; pulse start and in_valid meanwhile → outputs constant, in_ready=0, state remains DONE. out_ready=1 → IDLE next edge, busy=0.
- Abort cases:
  - clear during RUN after 2 beats → IDLE, count=0, out_valid never asserted.
  - rst_n low mid-RUN (async, off-edge) → all outputs at reset values immediately.
  - start+clear together in IDLE → stays IDLE.
